// File: rtl/rx_mac.sv
// rx_mac: 32-bit XGMII receive MAC producing an AXI-Stream payload with CRC-32/length checking.
// Define RX_MAC_ADDR_FILTER_EN to drop frames whose DA is neither LOCAL_MAC nor broadcast.
module rx_mac #(
   parameter int          AXIS_DATA_WIDTH  = 32,
   parameter int          AXIS_DATA_BYTES  = AXIS_DATA_WIDTH/8,
   parameter int          XGMII_DATA_WIDTH = 32,
   parameter int          XGMII_DATA_BYTES = XGMII_DATA_WIDTH/8,
   parameter int          MIN_FRAME_BYTES  = 64,
   parameter int          MAX_FRAME_BYTES  = 1518,
   parameter logic [47:0] LOCAL_MAC        = 48'h00_11_22_33_44_55
) (
   input  logic                        rx_clk,
   input  logic                        rx_rst,
   input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
   input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
   input  logic                        in_xgmii_valid,
   output logic [AXIS_DATA_WIDTH-1:0]  out_master_rx_tdata,
   output logic [AXIS_DATA_BYTES-1:0]  out_master_rx_tkeep,
   output logic                        out_master_rx_tvalid,
   output logic                        out_master_rx_tlast,
   output logic                        out_master_rx_tuser,
   output logic                        frame_valid,
   output logic                        frame_error
);

   localparam logic [7:0]  C_TERM  = 8'hFD;
   localparam logic [31:0] W_START = 32'h555555FB;
   localparam logic [31:0] W_SFD   = 32'hD5555555;
   localparam logic [31:0] W_IDLE  = 32'h07070707;
   localparam logic [10:0] L_MIN   = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] L_MAX   = 11'(MAX_FRAME_BYTES);
`ifdef RX_MAC_ADDR_FILTER_EN
   localparam logic FILTER_EN = 1'b1;
`else
   localparam logic FILTER_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   function automatic logic [31:0] f_crc_word(input logic [31:0] c, input logic [31:0] d,
                                              input logic [2:0] n);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++)
         if (i < int'(n)) r = f_crc_byte(r, d[8*i +: 8]);
      return r;
   endfunction

   // Register is kept LSB-first; the residue is checked in MSB-first orientation.
   function automatic logic [31:0] f_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic logic [3:0] f_keep(input logic [1:0] k);
      logic [3:0] m;
      case (k)
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         2'd3:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   state_t      r_state, w_state_nxt;
   logic [31:0] r_crc, w_crc_nxt;
   logic [10:0] r_cnt, w_cnt_nxt;
   logic        r_err, w_err_nxt;
   logic [31:0] r_a, w_a_nxt, r_b, w_b_nxt;
   logic        r_a_vld, w_a_vld_nxt, r_b_vld, w_b_vld_nxt;
   logic        r_first, w_first_nxt;
   logic        r_quiet, w_quiet_nxt;
   logic        r_pend_vld, w_pend_vld_nxt;
   logic [31:0] r_pend_data, w_pend_data_nxt;
   logic [3:0]  r_pend_keep, w_pend_keep_nxt;
   logic        r_pend_user, w_pend_user_nxt;
   logic [31:0] r_tdata, w_tdata_nxt;
   logic [3:0]  r_tkeep, w_tkeep_nxt;
   logic        r_tvalid, w_tvalid_nxt, r_tlast, w_tlast_nxt, r_tuser, w_tuser_nxt;
   logic        r_fv, w_fv_nxt, r_fe, w_fe_nxt;

   logic [1:0]  w_lo_lane;
   logic        w_lo_ctl, w_lo_fd, w_has_fd;
   logic        w_start, w_sfd, w_idle_w, w_end_word;
   logic [1:0]  w_end_k;
   logic [31:0] w_crc_end;
   logic [11:0] w_sum;
   logic [10:0] w_total, w_cnt_inc;
   logic        w_bad;
   logic [47:0] w_da;
   logic        w_da_hit, w_filt_drop;

   // Lowest control lane decides between terminate and error.
   always_comb begin
      w_lo_lane = 2'd0;
      w_lo_ctl  = 1'b0;
      w_lo_fd   = 1'b0;
      w_has_fd  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (in_xgmii_ctl[i]) begin
            w_lo_lane = 2'(i);
            w_lo_ctl  = 1'b1;
            w_lo_fd   = (in_xgmii_data[8*i +: 8] == C_TERM);
            if (in_xgmii_data[8*i +: 8] == C_TERM) w_has_fd = 1'b1;
         end
      end
   end

   assign w_start    = (in_xgmii_ctl == 4'b0001) && (in_xgmii_data == W_START);
   assign w_sfd      = (in_xgmii_ctl == 4'b0000) && (in_xgmii_data == W_SFD);
   assign w_idle_w   = (in_xgmii_ctl == 4'b1111) && (in_xgmii_data == W_IDLE);
   assign w_end_word = w_lo_fd | w_idle_w;
   assign w_end_k    = w_lo_fd ? w_lo_lane : 2'd0;

   assign w_crc_end = f_crc_word(r_crc, in_xgmii_data, {1'b0, w_end_k});
   assign w_sum     = {1'b0, r_cnt} + {10'd0, w_end_k};
   assign w_total   = w_sum[11] ? 11'h7FF : w_sum[10:0];
   assign w_cnt_inc = (r_cnt > 11'd2043) ? 11'h7FF : r_cnt + 11'd4;
   assign w_bad     = (f_rev(w_crc_end) != 32'hC704DD7B) || (w_total < L_MIN) ||
                      (w_total > L_MAX) || r_err || w_idle_w;

   assign w_da        = {r_b[7:0], r_b[15:8], r_b[23:16], r_b[31:24], r_a[7:0], r_a[15:8]};
   assign w_da_hit    = (w_da == LOCAL_MAC) || (w_da == 48'hFFFF_FFFF_FFFF);
   assign w_filt_drop = FILTER_EN && r_first && !w_da_hit;

   always_comb begin
      w_state_nxt     = r_state;
      w_crc_nxt       = r_crc;
      w_cnt_nxt       = r_cnt;
      w_err_nxt       = r_err;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_a_vld_nxt     = r_a_vld;
      w_b_vld_nxt     = r_b_vld;
      w_first_nxt     = r_first;
      w_quiet_nxt     = r_quiet;
      w_pend_vld_nxt  = 1'b0;
      w_pend_data_nxt = r_pend_data;
      w_pend_keep_nxt = r_pend_keep;
      w_pend_user_nxt = r_pend_user;
      w_tdata_nxt     = '0;
      w_tkeep_nxt     = '0;
      w_tvalid_nxt    = 1'b0;
      w_tlast_nxt     = 1'b0;
      w_tuser_nxt     = 1'b0;
      w_fv_nxt        = 1'b0;
      w_fe_nxt        = 1'b0;

      // Trailing partial beat goes out regardless of what the PCS is sending now.
      if (r_pend_vld) begin
         w_tvalid_nxt = 1'b1;
         w_tdata_nxt  = r_pend_data;
         w_tkeep_nxt  = r_pend_keep;
         w_tlast_nxt  = 1'b1;
         w_tuser_nxt  = r_pend_user;
         w_fv_nxt     = !r_pend_user;
         w_fe_nxt     = r_pend_user;
      end

      if (in_xgmii_valid) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  w_state_nxt = S_PRE;
                  w_crc_nxt   = 32'hFFFFFFFF;
                  w_cnt_nxt   = 11'd0;
                  w_err_nxt   = 1'b0;
                  w_a_vld_nxt = 1'b0;
                  w_b_vld_nxt = 1'b0;
                  w_first_nxt = 1'b1;
                  w_quiet_nxt = 1'b0;
               end
            end
            S_PRE: begin
               if (w_sfd) begin
                  w_state_nxt = S_DATA;
               end else if (w_has_fd || w_idle_w) begin
                  w_state_nxt = S_IDLE;
                  w_fe_nxt    = 1'b1;
               end else begin
                  w_state_nxt = S_DROP;
                  w_quiet_nxt = 1'b0;
               end
            end
            S_DATA: begin
               if (!w_end_word) begin
                  // Plain data, or a stray control word that poisons the frame.
                  if (w_lo_ctl) w_err_nxt = 1'b1;
                  w_crc_nxt   = f_crc_word(r_crc, in_xgmii_data, 3'd4);
                  w_cnt_nxt   = w_cnt_inc;
                  w_b_nxt     = r_a;
                  w_b_vld_nxt = r_a_vld;
                  w_a_nxt     = in_xgmii_data;
                  w_a_vld_nxt = 1'b1;
                  if (r_a_vld && r_b_vld) begin
                     if (w_filt_drop) begin
                        w_state_nxt = S_DROP;
                        w_quiet_nxt = 1'b1;
                        w_a_vld_nxt = 1'b0;
                        w_b_vld_nxt = 1'b0;
                     end else begin
                        w_tvalid_nxt = 1'b1;
                        w_tdata_nxt  = r_b;
                        w_tkeep_nxt  = 4'b1111;
                        w_first_nxt  = 1'b0;
                     end
                  end
               end else begin
                  w_state_nxt = S_IDLE;
                  w_crc_nxt   = w_crc_end;
                  w_a_vld_nxt = 1'b0;
                  w_b_vld_nxt = 1'b0;
                  if (!r_b_vld) begin
                     w_fe_nxt = 1'b1;
                  end else if (!w_filt_drop) begin
                     w_tvalid_nxt = 1'b1;
                     w_tdata_nxt  = r_b;
                     w_tkeep_nxt  = 4'b1111;
                     if (w_end_k == 2'd0) begin
                        w_tlast_nxt = 1'b1;
                        w_tuser_nxt = w_bad;
                        w_fv_nxt    = !w_bad;
                        w_fe_nxt    = w_bad;
                     end else begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_data_nxt = r_a;
                        w_pend_keep_nxt = f_keep(w_end_k);
                        w_pend_user_nxt = w_bad;
                     end
                  end
               end
            end
            S_DROP: begin
               if (w_has_fd || w_idle_w) begin
                  w_state_nxt = S_IDLE;
                  w_fe_nxt    = !r_quiet;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         r_state     <= S_IDLE;
         r_crc       <= 32'hFFFFFFFF;
         r_cnt       <= 11'd0;
         r_err       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_a_vld     <= 1'b0;
         r_b_vld     <= 1'b0;
         r_first     <= 1'b0;
         r_quiet     <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_data <= '0;
         r_pend_keep <= '0;
         r_pend_user <= 1'b0;
         r_tdata     <= '0;
         r_tkeep     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_tuser     <= 1'b0;
         r_fv        <= 1'b0;
         r_fe        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_crc       <= w_crc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_err       <= w_err_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_a_vld     <= w_a_vld_nxt;
         r_b_vld     <= w_b_vld_nxt;
         r_first     <= w_first_nxt;
         r_quiet     <= w_quiet_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_pend_data <= w_pend_data_nxt;
         r_pend_keep <= w_pend_keep_nxt;
         r_pend_user <= w_pend_user_nxt;
         r_tdata     <= w_tdata_nxt;
         r_tkeep     <= w_tkeep_nxt;
         r_tvalid    <= w_tvalid_nxt;
         r_tlast     <= w_tlast_nxt;
         r_tuser     <= w_tuser_nxt;
         r_fv        <= w_fv_nxt;
         r_fe        <= w_fe_nxt;
      end
   end

   assign out_master_rx_tdata  = r_tdata;
   assign out_master_rx_tkeep  = r_tkeep;
   assign out_master_rx_tvalid = r_tvalid;
   assign out_master_rx_tlast  = r_tlast;
   assign out_master_rx_tuser  = r_tuser;
   assign frame_valid          = r_fv;
   assign frame_error          = r_fe;

endmodule

// File: tb/tb_rx_mac.sv
// tb_rx_mac: directed frame table plus back-to-back and mid-frame reset sequences for rx_mac.
module tb_rx_mac;
   logic        rx_clk = 1'b0;
   logic        rx_rst;
   logic [31:0] in_xgmii_data;
   logic [3:0]  in_xgmii_ctl;
   logic        in_xgmii_valid;
   logic [31:0] out_master_rx_tdata;
   logic [3:0]  out_master_rx_tkeep;
   logic        out_master_rx_tvalid, out_master_rx_tlast, out_master_rx_tuser;
   logic        frame_valid, frame_error;

   rx_mac dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst),
      .in_xgmii_data(in_xgmii_data), .in_xgmii_ctl(in_xgmii_ctl), .in_xgmii_valid(in_xgmii_valid),
      .out_master_rx_tdata(out_master_rx_tdata), .out_master_rx_tkeep(out_master_rx_tkeep),
      .out_master_rx_tvalid(out_master_rx_tvalid), .out_master_rx_tlast(out_master_rx_tlast),
      .out_master_rx_tuser(out_master_rx_tuser),
      .frame_valid(frame_valid), .frame_error(frame_error)
   );

   always #5 rx_clk = ~rx_clk;

   localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

   typedef struct {
      int          len;     // DA through FCS
      logic [7:0]  sfd;
      int          seed;
      bit          corrupt;
      int          fe_w;    // data word replaced by an FE control word, -1 = none
      bit          gap;     // valid-low filler between words
      logic [47:0] da;
      int          beats;   // -1 = not checked
      logic [3:0]  lkeep;
      int          tlasts;
      bit          tuser;
      int          fv;
      int          fe;
      bit          chk;     // compare payload bytes
   } vec_t;

   vec_t        tbl[$];
   int          n_cmp = 0, n_err = 0;
   logic [7:0]  fr[0:2047];
   logic [7:0]  exp_q[$], got_q[$];
   int          m_beats, m_tlasts, m_fv, m_fe, m_badkeep;
   logic [3:0]  m_lkeep;
   logic        m_luser;
   bit          g_gap = 1'b0;

   always @(negedge rx_clk) begin
      if (!rx_rst) begin
         if (out_master_rx_tvalid) begin
            m_beats++;
            for (int j = 0; j < 4; j++)
               if (out_master_rx_tkeep[j]) got_q.push_back(out_master_rx_tdata[8*j +: 8]);
            if (out_master_rx_tlast) begin
               m_tlasts++;
               m_lkeep = out_master_rx_tkeep;
               m_luser = out_master_rx_tuser;
            end else if (out_master_rx_tkeep != 4'hF) m_badkeep++;
         end
         if (frame_valid) m_fv++;
         if (frame_error) m_fe++;
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic mon_clear();
      m_beats = 0; m_tlasts = 0; m_fv = 0; m_fe = 0; m_badkeep = 0;
      m_lkeep = 4'h0; m_luser = 1'b0;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic chk_payload(input string nm);
      int bad;
      bad = 0;
      chk({nm, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      chk({nm, "_bytes_wrong"}, bad, 0);
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int j = 0; j < 8; j++) r = (r[0] ^ b[j]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [7:0] body_byte(input int i, input logic [47:0] da, input int seed);
      logic [47:0] sa;
      sa = 48'h02_00_00_00_00_01;
      if (i < 6)        return da[8*(5-i) +: 8];
      else if (i < 12)  return sa[8*(11-i) +: 8];
      else if (i == 12) return 8'h08;
      else if (i == 13) return 8'h00;
      else              return 8'((i * seed) & 255);
   endfunction

   task automatic tick(input logic [31:0] d, input logic [3:0] c);
      if (g_gap) begin
         @(posedge rx_clk); #1;
         in_xgmii_data = 32'h07FD07FD; in_xgmii_ctl = 4'hF; in_xgmii_valid = 1'b0;
      end
      @(posedge rx_clk); #1;
      in_xgmii_data = d; in_xgmii_ctl = c; in_xgmii_valid = 1'b1;
   endtask

   task automatic send_frame(input vec_t v, input int idles_after);
      logic [31:0] crc, w;
      logic [3:0]  c;
      int          nb, nf, k;
      nb  = v.len - 4;
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < nb; i++) begin
         fr[i] = body_byte(i, v.da, v.seed);
         crc   = crc_upd(crc, fr[i]);
      end
      crc = ~crc;
      for (int j = 0; j < 4; j++) fr[nb+j] = crc[8*j +: 8];
      if (v.corrupt) fr[20][3] = ~fr[20][3];
      if (v.fe_w >= 0) fr[4*v.fe_w] = 8'hFE;
      if (v.beats > 0 && v.chk)
         for (int i = 0; i < nb; i++) exp_q.push_back(fr[i]);
      g_gap = v.gap;
      tick(32'h555555FB, 4'b0001);
      tick({v.sfd, 24'h555555}, 4'b0000);
      nf = v.len / 4;
      k  = v.len % 4;
      for (int i = 0; i < nf; i++) begin
         w = {fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]};
         tick(w, (i == v.fe_w) ? 4'b0001 : 4'b0000);
      end
      w = 32'h07070707;
      c = 4'b0000;
      for (int j = 0; j < 4; j++) begin
         if (j < k) w[8*j +: 8] = fr[4*nf+j];
         else begin
            c[j] = 1'b1;
            w[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
         end
      end
      tick(w, c);
      g_gap = 1'b0;
      repeat (idles_after) tick(32'h07070707, 4'hF);
   endtask

   initial begin
      vec_t v, v2;
      rx_rst = 1'b1;
      in_xgmii_data = 32'h07070707; in_xgmii_ctl = 4'hF; in_xgmii_valid = 1'b0;
      mon_clear();
      repeat (2) @(posedge rx_clk);
      #1;
      chk("reset_tdata", int'(out_master_rx_tdata), 0);
      chk("reset_tkeep", int'(out_master_rx_tkeep), 0);
      chk("reset_flags", int'({out_master_rx_tvalid, out_master_rx_tlast, out_master_rx_tuser,
                               frame_valid, frame_error}), 0);
      rx_rst = 1'b0;
      tick(32'h07070707, 4'hF);

      //              len   sfd   seed cor fe gap da  beats keep tl tu fv fe chk
      tbl.push_back('{64,   8'hD5, 0, 1'b0, -1, 1'b0, MAC, 15,  4'hF, 1, 1'b0, 1, 0, 1'b1});
      tbl.push_back('{63,   8'hD5, 3, 1'b0, -1, 1'b0, MAC, 15,  4'h7, 1, 1'b1, 0, 1, 1'b1});
      tbl.push_back('{65,   8'hD5, 9, 1'b0, -1, 1'b0, MAC, 16,  4'h1, 1, 1'b0, 1, 0, 1'b1});
      tbl.push_back('{64,   8'hD5, 0, 1'b1, -1, 1'b0, MAC, 15,  4'hF, 1, 1'b1, 0, 1, 1'b1});
      tbl.push_back('{64,   8'hD4, 0, 1'b0, -1, 1'b0, MAC, 0,   4'h0, 0, 1'b0, 0, 1, 1'b1});
      tbl.push_back('{64,   8'hD5, 7, 1'b0,  5, 1'b0, MAC, -1,  4'hF, 1, 1'b1, 0, 1, 1'b0});
      tbl.push_back('{66,   8'hD5, 5, 1'b0, -1, 1'b1, MAC, 16,  4'h3, 1, 1'b0, 1, 0, 1'b1});
      tbl.push_back('{1518, 8'hD5, 1, 1'b0, -1, 1'b0, MAC, 379, 4'h3, 1, 1'b0, 1, 0, 1'b1});
      tbl.push_back('{1519, 8'hD5, 1, 1'b0, -1, 1'b0, MAC, 379, 4'h7, 1, 1'b1, 0, 1, 1'b1});
      tbl.push_back('{7,    8'hD5, 0, 1'b0, -1, 1'b0, MAC, 0,   4'h0, 0, 1'b0, 0, 1, 1'b1});
`ifdef RX_MAC_ADDR_FILTER_EN
      tbl.push_back('{64, 8'hD5, 2, 1'b0, -1, 1'b0, 48'h00_11_22_33_44_56, 0, 4'h0, 0, 1'b0, 0, 0, 1'b1});
      tbl.push_back('{64, 8'hD5, 2, 1'b0, -1, 1'b0, 48'hFF_FF_FF_FF_FF_FF, 15, 4'hF, 1, 1'b0, 1, 0, 1'b1});
`else
      tbl.push_back('{8,    8'hD5, 0, 1'b0, -1, 1'b0, MAC, 1,   4'hF, 1, 1'b1, 0, 1, 1'b1});
`endif

      foreach (tbl[i]) begin
         string nm;
         nm = $sformatf("v%0d_len%0d", i, tbl[i].len);
         mon_clear();
         send_frame(tbl[i], 8);
         if (tbl[i].beats >= 0) chk({nm, "_beats"}, m_beats, tbl[i].beats);
         chk({nm, "_tlasts"}, m_tlasts, tbl[i].tlasts);
         if (tbl[i].tlasts > 0) begin
            chk({nm, "_last_tkeep"}, int'(m_lkeep), int'(tbl[i].lkeep));
            chk({nm, "_last_tuser"}, int'(m_luser), int'(tbl[i].tuser));
         end
         chk({nm, "_frame_valid"}, m_fv, tbl[i].fv);
         chk({nm, "_frame_error"}, m_fe, tbl[i].fe);
         chk({nm, "_mid_tkeep"}, m_badkeep, 0);
         if (tbl[i].chk) chk_payload({nm, "_payload"});
      end

      // Back-to-back: next Start two words after a terminate in lane 1.
      mon_clear();
      v  = tbl[2];
      v2 = tbl[0];
      send_frame(v, 1);
      send_frame(v2, 8);
      chk("b2b_beats", m_beats, 31);
      chk("b2b_tlasts", m_tlasts, 2);
      chk("b2b_frame_valid", m_fv, 2);
      chk("b2b_frame_error", m_fe, 0);
      chk("b2b_last_tuser", int'(m_luser), 0);
      chk_payload("b2b_payload");

      // Reset in the middle of a streaming payload.
      mon_clear();
      tick(32'h555555FB, 4'b0001);
      tick(32'hD5555555, 4'b0000);
      for (int i = 0; i < 8; i++) tick(32'hA5A50000 + i, 4'b0000);
      @(posedge rx_clk); #2;
      chk("pre_reset_tvalid", int'(out_master_rx_tvalid), 1);
      rx_rst = 1'b1;
      in_xgmii_data = 32'h07070707; in_xgmii_ctl = 4'hF; in_xgmii_valid = 1'b0;
      #1;
      chk("async_reset_tvalid", int'(out_master_rx_tvalid), 0);
      chk("async_reset_tdata", int'(out_master_rx_tdata), 0);
      chk("async_reset_flags", int'({out_master_rx_tkeep, out_master_rx_tlast, out_master_rx_tuser,
                                     frame_valid, frame_error}), 0);
      @(posedge rx_clk); #1;
      rx_rst = 1'b0;
      repeat (3) tick(32'h07070707, 4'hF);
      mon_clear();
      send_frame(tbl[0], 8);
      chk("post_reset_beats", m_beats, 15);
      chk("post_reset_tlasts", m_tlasts, 1);
      chk("post_reset_frame_valid", m_fv, 1);
      chk("post_reset_frame_error", m_fe, 0);
      chk_payload("post_reset_payload");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
